// File: rtl/tx_pkg.sv
// Shared types and constants for the per-channel radio packetizer.
package tx_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, ADDR, FETCH, PAIR, CSUM, GAP} tx_state_e;

    localparam logic [23:0] FRAME1  = 24'haab155;
    localparam logic [23:0] FRAME0  = 24'haa8d55;
    localparam logic [7:0]  HSYNC   = 8'haa;
    localparam int          HDR_LEN = 5;

    // One byte request into the output register; inc marks checksum coverage.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       inc;
    } byte_req_t;

    function automatic logic [7:0] hdr_byte(logic [23:0] w, logic [1:0] idx);
        case (idx)
            2'd0:    return w[23:16];
            2'd1:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/tx_chan_packetizer_if.sv
// AXI-Stream byte channel from the packetizer to the radio FIFO driver.
interface tx_chan_packetizer_if;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;

    modport master (output m_axis_tdata, output m_axis_tvalid, output m_axis_tlast,
                    input  m_axis_tready);
    modport slave  (input  m_axis_tdata, input  m_axis_tvalid, input  m_axis_tlast,
                    output m_axis_tready);
endinterface

// File: rtl/tx_byte_out.sv
// AXIS output register: holds its byte while stalled and folds covered bytes
// into the running XOR checksum as they actually transfer.
module tx_byte_out
    import tx_pkg::*;
(
    input  logic       Cclk,
    input  logic       rstn,
    input  logic       ld,
    input  byte_req_t  req,
    input  logic       csum_clr,
    input  logic       tready,
    output logic [7:0] tdata,
    output logic       tvalid,
    output logic       tlast,
    output logic       can_ld,
    output logic [7:0] csum_nxt
);
    logic       tinc;
    logic [7:0] csum;
    logic       xfer;

    assign xfer     = tvalid & tready;
    assign can_ld   = ~tvalid | tready;
    // Includes a byte leaving this very cycle, so the checksum byte can follow back-to-back.
    assign csum_nxt = (xfer & tinc) ? (csum ^ tdata) : csum;

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            tdata  <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            tinc   <= 1'b0;
            csum   <= '0;
        end else begin
            csum <= csum_clr ? 8'h00 : csum_nxt;
            if (ld && can_ld) begin
                tdata  <= req.data;
                tlast  <= req.last;
                tinc   <= req.inc;
                tvalid <= 1'b1;
            end else if (xfer) begin
                tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tx_chan_packetizer.sv
// Per-channel packet builder: pulls 12-bit samples from frame memory and
// streams sync / address / pixel-pair payload / XOR checksum bytes over AXIS.
module tx_chan_packetizer #(
    parameter int          PAYLOAD_PIX = 32,
    parameter int          FETCH_WAIT  = 6,
    parameter int          GAP_CYCLES  = 16,
    parameter logic [23:0] FRAME1      = tx_pkg::FRAME1,
    parameter logic [23:0] FRAME0      = tx_pkg::FRAME0
) (
    input  logic                  Cclk,
    input  logic                  rstn,
    input  logic                  tran_en,
    input  logic [11:0]           tran_data,
    input  logic [15:0]           tran_add,
    input  logic                  tran_frame_sync,
    output logic                  tran_next_data,
    output logic                  busy,
    tx_chan_packetizer_if.master  axis
);
    import tx_pkg::*;

    localparam int PW = $clog2(PAYLOAD_PIX) + 1;
    localparam int CW = $clog2(FETCH_WAIT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    tx_state_e     state, state_nxt;
    logic [CW-1:0] wcnt;
    logic [PW-1:0] pix_cnt;
    logic [GW-1:0] gcnt;
    logic [1:0]    bcnt;
    logic          sync_sel, pad, have_a;
    logic [15:0]   addr_q;
    logic [11:0]   pix_a, pix_b, pix_in;
    logic          wait_ok, pad_now, pix_take, start;
    logic          ld, can_ld;
    byte_req_t     req;
    logic [7:0]    csum_nxt;

    // wcnt measures time since the last next-data pulse or since tran_en rose.
    assign wait_ok  = (wcnt == CW'(FETCH_WAIT));
    assign pad_now  = pad | ~tran_en;
    assign pix_take = (state == FETCH) & (pad_now | wait_ok);
    assign pix_in   = pad_now ? 12'h000 : tran_data;
    assign start    = tran_en & wait_ok;

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SYNC;
            SYNC:    if (can_ld && bcnt == 2'd2) state_nxt = ADDR;
            ADDR:    if (can_ld && bcnt == 2'd1) state_nxt = FETCH;
            FETCH:   if (pix_take && have_a) state_nxt = PAIR;
            PAIR:    if (can_ld && bcnt == 2'd2)
                         state_nxt = (pix_cnt < PW'(PAYLOAD_PIX)) ? FETCH : CSUM;
            CSUM:    if (can_ld) state_nxt = GAP;
            GAP:     if (!axis.m_axis_tvalid && gcnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld             = 1'b0;
        req            = '0;
        tran_next_data = 1'b0;
        case (state)
            SYNC: begin
                ld       = 1'b1;
                req.data = hdr_byte(sync_sel ? FRAME1 : FRAME0, bcnt);
            end
            ADDR: begin
                ld       = 1'b1;
                req.inc  = 1'b1;
                req.data = bcnt[0] ? addr_q[7:0] : addr_q[15:8];
            end
            FETCH: tran_next_data = pix_take & ~pad_now;
            PAIR: begin
                ld      = 1'b1;
                req.inc = 1'b1;
                case (bcnt)
                    2'd0:    req.data = pix_a[11:4];
                    2'd1:    req.data = {pix_a[3:0], pix_b[11:8]};
                    default: req.data = pix_b[7:0];
                endcase
            end
            CSUM: begin
                ld       = 1'b1;
                req.last = 1'b1;
                req.data = csum_nxt;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            wcnt     <= '0;
            pix_cnt  <= '0;
            gcnt     <= '0;
            bcnt     <= '0;
            sync_sel <= 1'b0;
            pad      <= 1'b0;
            have_a   <= 1'b0;
            addr_q   <= '0;
            pix_a    <= '0;
            pix_b    <= '0;
        end else begin
            if (tran_next_data)  wcnt <= CW'(1);
            else if (!tran_en)   wcnt <= '0;
            else if (!wait_ok)   wcnt <= wcnt + CW'(1);
            // Once the channel drops mid-packet the rest is padding, even if it comes back.
            if (state != IDLE && !tran_en) pad <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    sync_sel <= tran_frame_sync;
                    addr_q   <= tran_add;
                    pad      <= 1'b0;
                    pix_cnt  <= '0;
                    have_a   <= 1'b0;
                    bcnt     <= '0;
                end
                SYNC, ADDR, PAIR: if (can_ld) bcnt <= (state_nxt != state) ? 2'd0 : bcnt + 2'd1;
                FETCH: if (pix_take) begin
                    if (have_a) pix_b <= pix_in;
                    else        pix_a <= pix_in;
                    have_a  <= ~have_a;
                    pix_cnt <= pix_cnt + PW'(1);
                end
                CSUM: gcnt <= '0;
                GAP:  if (!axis.m_axis_tvalid) gcnt <= gcnt + GW'(1);
                default: ;
            endcase
        end
    end

    tx_byte_out u_out (
        .Cclk     (Cclk),
        .rstn     (rstn),
        .ld       (ld),
        .req      (req),
        .csum_clr (state == IDLE),
        .tready   (axis.m_axis_tready),
        .tdata    (axis.m_axis_tdata),
        .tvalid   (axis.m_axis_tvalid),
        .tlast    (axis.m_axis_tlast),
        .can_ld   (can_ld),
        .csum_nxt (csum_nxt)
    );

endmodule

// File: tb/tb_tx_chan_packetizer.sv
// Randomized bench: frame-memory model with fetch latency, AXIS sink with
// optional back-pressure, and a packet-level reference built from the layout rules.
module tb_tx_chan_packetizer;
    localparam int PIX = 4;
    localparam int FW  = 6;
    localparam int GAP = 16;

    logic        Cclk = 1'b0;
    logic        rstn;
    logic        tran_en, tran_frame_sync, tran_next_data, busy;
    logic [11:0] tran_data;
    logic [15:0] tran_add;
    logic        rdy = 1'b1;
    logic        rnd_rdy = 1'b0;

    tx_chan_packetizer_if axis();

    tx_chan_packetizer #(.PAYLOAD_PIX(PIX), .FETCH_WAIT(FW), .GAP_CYCLES(GAP)) dut (
        .Cclk            (Cclk),
        .rstn            (rstn),
        .tran_en         (tran_en),
        .tran_data       (tran_data),
        .tran_add        (tran_add),
        .tran_frame_sync (tran_frame_sync),
        .tran_next_data  (tran_next_data),
        .busy            (busy),
        .axis            (axis)
    );

    always #5 Cclk = ~Cclk;
    assign axis.m_axis_tready = rdy;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Frame memory: data valid FW cycles after a next-data pulse or tran_en rising.
    int          mode = 0;
    logic [15:0] base_v = '0;
    logic [11:0] seed = '0;
    logic        set_base = 1'b0;
    logic [15:0] m_addr = '0;
    int          m_tmr = FW;

    function automatic logic [11:0] mem_val(input logic [15:0] a);
        case (mode)
            0:       return 12'habc;
            1:       return 12'(a - base_v + 16'd1);
            default: return 12'(a * 16'h9e37) ^ 12'(a >> 5) ^ seed;
        endcase
    endfunction

    always @(posedge Cclk) begin
        if (set_base)            m_addr <= base_v;
        else if (tran_next_data) m_addr <= m_addr + 16'd1;
        if (tran_next_data)      m_tmr <= FW - 1;
        else if (!tran_en)       m_tmr <= FW;
        else if (m_tmr != 0)     m_tmr <= m_tmr - 1;
    end

    assign tran_add  = m_addr;
    assign tran_data = (m_tmr == 0) ? mem_val(m_addr) : ~mem_val(m_addr);

    always @(posedge Cclk) begin
        #1;
        rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Sink monitor
    logic [7:0] rx_q[$];
    logic       rx_l[$];
    int         n_pulse = 0, n_pkt = 0, gap_run = 0, min_gap = 1000;
    logic       in_gap = 1'b0, prev_stall = 1'b0, prev_l = 1'b0;
    logic [7:0] prev_d = '0;

    always @(negedge Cclk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
            in_gap     = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", axis.m_axis_tvalid, 1'b1);
                chk("hold_data", axis.m_axis_tdata, prev_d);
                chk("hold_last", axis.m_axis_tlast, prev_l);
            end
            if (tran_next_data) n_pulse++;
            if (axis.m_axis_tvalid && rdy) begin
                rx_q.push_back(axis.m_axis_tdata);
                rx_l.push_back(axis.m_axis_tlast);
            end
            if (axis.m_axis_tvalid && rdy && axis.m_axis_tlast) begin
                n_pkt++;
                in_gap  = 1'b1;
                gap_run = 0;
            end else if (in_gap) begin
                if (!axis.m_axis_tvalid) gap_run++;
                else begin
                    if (gap_run < min_gap) min_gap = gap_run;
                    in_gap = 1'b0;
                end
            end
            prev_stall = axis.m_axis_tvalid & ~rdy;
            prev_d     = axis.m_axis_tdata;
            prev_l     = axis.m_axis_tlast;
        end
    end

    // Reference packet: sync, addr, pixel pairs (zero after nval), xor checksum.
    logic [7:0] exp_q[$];
    logic       exp_l[$];

    task automatic add_exp(input logic [15:0] a, input logic fs, input int nval);
        logic [11:0] px[PIX];
        logic [7:0]  b[$];
        logic [23:0] sw;
        logic [7:0]  cs;
        sw = fs ? 24'haab155 : 24'haa8d55;
        for (int i = 0; i < PIX; i++) px[i] = (i < nval) ? mem_val(16'(a + i)) : 12'h000;
        b.push_back(a[15:8]);
        b.push_back(a[7:0]);
        for (int i = 0; i < PIX; i += 2) begin
            b.push_back(px[i][11:4]);
            b.push_back({px[i][3:0], px[i+1][11:8]});
            b.push_back(px[i+1][7:0]);
        end
        cs = 8'h00;
        foreach (b[i]) cs ^= b[i];
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(sw[23 - 8*i -: 8]);
            exp_l.push_back(1'b0);
        end
        foreach (b[i]) begin
            exp_q.push_back(b[i]);
            exp_l.push_back(1'b0);
        end
        exp_q.push_back(cs);
        exp_l.push_back(1'b1);
    endtask

    task automatic cmp_rx(input string tag);
        int n;
        chk({tag, "_len"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
            chk($sformatf("%s_l%0d", tag, i), rx_l[i], exp_l[i]);
        end
    endtask

    task automatic clr_rx();
        rx_q.delete(); rx_l.delete(); exp_q.delete(); exp_l.delete();
        n_pulse = 0; n_pkt = 0; min_gap = 1000; in_gap = 1'b0;
    endtask

    task automatic wait_pkts(input int npk, input int drop, input logic fs, input logic wiggle);
        int t;
        for (t = 0; t < 4000 && n_pkt < npk; t++) begin
            @(posedge Cclk); #1;
            if (drop > 0 && n_pulse >= drop) tran_en = 1'b0;
            if (wiggle) tran_frame_sync = busy ? ~fs : fs;
        end
        if (n_pkt < npk) chk("timeout_pkts", n_pkt, npk);
        tran_en = 1'b0;
        repeat (GAP + 8) @(posedge Cclk);
        #1;
    endtask

    task automatic run(input logic [15:0] base, input logic fs, input int md,
                       input int npk, input int drop);
        mode = md; base_v = base; set_base = 1'b1;
        @(posedge Cclk); #1;
        set_base = 1'b0;
        clr_rx();
        tran_frame_sync = fs;
        tran_en = 1'b1;
        wait_pkts(npk, drop, fs, 1'b1);
        for (int k = 0; k < npk; k++) add_exp(16'(base + k * PIX), fs, (drop > 0) ? drop : PIX);
        cmp_rx("pkt");
        chk("pulses", n_pulse, (drop > 0) ? drop : npk * PIX);
        chk("idle_busy", busy, 1'b0);
        if (npk > 1) chk("gap_ok", min_gap >= GAP, 1'b1);
    endtask

    logic [7:0]  lit[12];
    logic [7:0]  saved[$];
    logic [15:0] b0, a_rel;
    int          t;

    initial begin
        rstn = 1'b0; tran_en = 1'b0; tran_frame_sync = 1'b0;
        repeat (3) @(posedge Cclk);
        #1;
        chk("rst_tvalid", axis.m_axis_tvalid, 1'b0);
        chk("rst_tlast", axis.m_axis_tlast, 1'b0);
        chk("rst_tdata", axis.m_axis_tdata, 8'h00);
        chk("rst_next", tran_next_data, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rstn = 1'b1;

        // Fixed sample, address 0, frame parity 1
        run(16'h0000, 1'b1, 0, 1, 0);
        lit = '{8'haa, 8'hb1, 8'h55, 8'h00, 8'h00, 8'hab, 8'hca, 8'hbc, 8'hab, 8'hca, 8'hbc, 8'h00};
        for (int i = 0; i < 12; i++)
            chk($sformatf("lit_b%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, lit[i]);

        // Incrementing samples from 0x0123, frame parity 0
        run(16'h0123, 1'b0, 1, 1, 0);

        // Same random traffic with and without back-pressure must match byte for byte
        seed = 12'($urandom); b0 = 16'($urandom);
        run(b0, 1'b1, 2, 2, 0);
        saved = rx_q;
        rnd_rdy = 1'b1;
        run(b0, 1'b1, 2, 2, 0);
        rnd_rdy = 1'b0;
        chk("stall_len", rx_q.size(), saved.size());
        for (int i = 0; i < saved.size() && i < rx_q.size(); i++)
            chk($sformatf("stall_b%0d", i), rx_q[i], saved[i]);

        // Channel disabled after the first pixel
        run(16'($urandom), 1'b1, 2, 1, 1);

        // Continuous enable over three packets
        run(16'h0000, 1'b0, 2, 3, 0);

        // Random mixes
        for (int r = 0; r < 4; r++) begin
            seed = 12'($urandom);
            rnd_rdy = 1'($urandom_range(0, 1));
            if (r[0]) run(16'($urandom), 1'($urandom), 2, 1, int'($urandom_range(1, PIX - 1)));
            else      run(16'($urandom), 1'($urandom), 2, 2, 0);
        end
        rnd_rdy = 1'b0;

        // Reset in the middle of the payload
        mode = 2; base_v = 16'h4000; set_base = 1'b1;
        @(posedge Cclk); #1;
        set_base = 1'b0;
        clr_rx();
        tran_frame_sync = 1'b1;
        tran_en = 1'b1;
        for (t = 0; t < 2000 && rx_q.size() < 6; t++) begin
            @(posedge Cclk); #1;
        end
        if (rx_q.size() < 6) chk("timeout_mid", rx_q.size(), 6);
        #2 rstn = 1'b0;
        #1;
        chk("mid_tvalid", axis.m_axis_tvalid, 1'b0);
        chk("mid_tlast", axis.m_axis_tlast, 1'b0);
        chk("mid_next", tran_next_data, 1'b0);
        chk("mid_busy", busy, 1'b0);
        @(posedge Cclk); #1;
        rstn = 1'b1;
        a_rel = m_addr;
        clr_rx();
        wait_pkts(1, 0, 1'b1, 1'b0);
        add_exp(a_rel, 1'b1, PIX);
        cmp_rx("rst_pkt");
        chk("rst_pulses", n_pulse, PIX);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
